// File: rtl/lfsr_rng_disp.sv
// Fibonacci LFSR random generator with synchronized step/run/load controls,
// period measurement and a registered active-low seven-segment hex display.

module lfsr_hex_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nib,
    output logic [7:0] seg
);
    // Bit 7 = a ... bit 1 = g, bit 0 = dp; active-low with dp always off.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 8'hFF;
        end else begin
            case (nib)
                4'h0: seg <= 8'h03;
                4'h1: seg <= 8'h9F;
                4'h2: seg <= 8'h25;
                4'h3: seg <= 8'h0D;
                4'h4: seg <= 8'h99;
                4'h5: seg <= 8'h49;
                4'h6: seg <= 8'h41;
                4'h7: seg <= 8'h1F;
                4'h8: seg <= 8'h01;
                4'h9: seg <= 8'h09;
                4'hA: seg <= 8'h11;
                4'hB: seg <= 8'hC1;
                4'hC: seg <= 8'h63;
                4'hD: seg <= 8'h85;
                4'hE: seg <= 8'h61;
                default: seg <= 8'h71;
            endcase
        end
    end
endmodule

module lfsr_rng_disp #(
    parameter int                WIDTH        = 8,
    parameter logic [WIDTH-1:0]  TAPS         = WIDTH'('h1D),
    parameter logic [WIDTH-1:0]  SEED_DEFAULT = WIDTH'(1),
    parameter int                DIV          = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step_in,
    input  logic                     run,
    input  logic                     load,
    input  logic [WIDTH-1:0]         seed,
    output logic [WIDTH-1:0]         q,
    output logic                     step_pulse,
    output logic                     wrap,
    output logic [WIDTH-1:0]         period,
    output logic [8*(WIDTH/4)-1:0]   seg
);
    localparam int              NDIG    = WIDTH / 4;
    localparam int              PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(DIV - 1);

    // [0],[1] = synchronizer, [2] = edge history; all reset high so a level
    // held through reset never looks like a rising edge.
    logic [2:0] step_sr, run_sr, load_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_sr <= 3'b111;
            run_sr  <= 3'b111;
            load_sr <= 3'b111;
        end else begin
            step_sr <= {step_sr[1:0], step_in};
            run_sr  <= {run_sr[1:0], run};
            load_sr <= {load_sr[1:0], load};
        end
    end

    logic step_edge, load_edge, run_on;
    assign step_edge = step_sr[1] & ~step_sr[2];
    assign load_edge = load_sr[1] & ~load_sr[2];
    assign run_on    = run_sr[1];

    logic [PW-1:0] pre;
    logic          tick;
    assign tick = run_on && (pre == PRE_MAX);

    logic [WIDTH-1:0] ref_val, cnt;
    logic [WIDTH-1:0] q_next, q_step, seed_eff;
    logic             fb, do_step;

    assign fb       = ^(q & TAPS);
    assign q_next   = {fb, q[WIDTH-1:1]};
    // The all-zero state would lock the register; reseed instead of shifting.
    assign q_step   = (q == '0) ? SEED_DEFAULT : q_next;
    assign seed_eff = (seed == '0) ? SEED_DEFAULT : seed;
    assign do_step  = step_edge | tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= SEED_DEFAULT;
            ref_val    <= SEED_DEFAULT;
            cnt        <= '0;
            period     <= '0;
            pre        <= '0;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
            if (load_edge) begin
                q       <= seed_eff;
                ref_val <= seed_eff;
                cnt     <= '0;
                pre     <= '0;
            end else begin
                if (!run_on || tick) pre <= '0;
                else                 pre <= pre + 1'b1;
                if (do_step) begin
                    q          <= q_step;
                    step_pulse <= 1'b1;
                    if (q_step == ref_val) begin
                        wrap   <= 1'b1;
                        period <= cnt + WIDTH'(1);
                        cnt    <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
            end
        end
    end

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        lfsr_hex_digit u_dig (
            .clk (clk),
            .rst (rst),
            .nib (q[4*d +: 4]),
            .seg (seg[8*d +: 8])
        );
    end
endmodule

// File: doc/lfsr_rng_disp.md
# lfsr_rng_disp

Parametrised pseudo-random generator with a built-in hex display driver, for board-level experiments. A Fibonacci LFSR of configurable width and tap set advances on a debounced-switch rising edge or automatically from a prescaler, accepts a runtime seed, recovers from the all-zero lock-up state, and measures the sequence period. The current state is driven to WIDTH/4 active-low seven-segment digits.

## Interface

- WIDTH, 8: LFSR width. Must be a multiple of 4, from 4 to 32.
- TAPS, 8'h1D: feedback mask, WIDTH bits. Bit i set means q[i] feeds the XOR. The default gives x^8+x^4+x^3+x^2+1, which is maximal.
- SEED_DEFAULT, 1: value loaded on reset, and substituted whenever a zero seed is loaded. Must be non-zero.
- DIV, 50_000_000: auto-run step period in clk cycles. Must be ≥1.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- step_in  in  1  asynchronous level input from a switch. Each rising edge advances one step.
- run  in  1  asynchronous level input. While high, the LFSR steps once every DIV cycles.
- load  in  1  asynchronous level input. A rising edge loads seed.
- seed  in  WIDTH  seed value. Sampled in the cycle the load edge is detected.
- q  out  WIDTH  current LFSR state.
- step_pulse  out  1  one-cycle pulse in the cycle after q changes due to a step.
- wrap  out  1  one-cycle pulse, concurrent with step_pulse, when a step returns q to the reference value.
- period  out  WIDTH  number of steps in the last completed cycle.
- seg  out  8*WIDTH/4  digit d occupies seg[8d+7:8d] and shows q[4d+3:4d]. Bit 7 is segment a, through bit 1 segment g, and bit 0 is dp. Active-low, so 1 means off.

## Operation

- Input conditioning:
  - step_in, run and load each pass through a 2-flop synchronizer, then an edge history register.
  - Synchronizer and history registers reset to 1, so an input held high through reset produces no edge.
- Step function: q_next = {^(q & TAPS), q[WIDTH-1:1]}, i.e. shift right with feedback into the MSB.
- Prescaler:
  - Counts 0..DIV-1 while synced run is high.
  - Asserts tick at DIV-1 and wraps to 0.
  - Held at 0 while run is low.
- Priority per cycle: rst > load edge > (step edge OR tick).
  - A step edge and a tick in the same cycle produce exactly one step.
- Load:
  - q <= (seed==0) ? SEED_DEFAULT : seed.
  - ref <= the same value.
  - Step counter <= 0 and prescaler <= 0.
  - No step_pulse or wrap.
- Zero-state recovery: if q==0 is ever observed (not reachable with legal TAPS, but defended), the next step loads SEED_DEFAULT instead of q_next.
- Period measurement: on each step, if q_next==ref then wrap=1, period <= cnt+1 and cnt <= 0; otherwise cnt <= cnt+1. cnt saturates at all-ones.
- Display:
  - Each nibble is registered through a hex decoder.
  - 0→0x03, 1→0x9F, 2→0x25, 3→0x0D, 4→0x99, 5→0x49, 6→0x41, 7→0x1F, 8→0x01, 9→0x09, A→0x11, b→0xC1, C→0x63, d→0x85, E→0x61, F→0x71.
  - dp is always off.

## Timing

- Reset values:
  - q=SEED_DEFAULT, ref=SEED_DEFAULT.
  - cnt=0, period=0, prescaler=0.
  - step_pulse=0, wrap=0.
  - seg = decode(SEED_DEFAULT), registered one cycle after reset. seg is 0xFF per digit during the reset cycle itself.
- Input-to-state latency: an input change sampled at edge k is seen by edge detection after edge k+1, so q updates at edge k+2. seg follows at edge k+3.
- step_pulse and wrap are high for exactly the one cycle after q changes.
- Auto-run: with run held high, consecutive steps are exactly DIV cycles apart. With DIV=1, q steps every cycle.
- A rising edge on run starts the prescaler at 0, so the first tick comes DIV cycles after synced run goes high.
- Reset asserted mid-run or mid-count overrides all pending edges and ticks in that cycle.
- A load edge coinciding with a tick suppresses the step. The prescaler restarts from 0.
- A held step_in produces a single step. Toggling faster than one edge per 2 cycles is unsupported.

## Test plan

- Reset, then four step_in rising edges, default params → q = 0x01→0x80→0x40→0x20→0x10, with one step_pulse each. Final seg digit0=0x03 and digit1=0x9F.
- Fifth step from 0x10 → q=0x88, seg digit1=digit0=0x01.
- load with seed=0x00 → q=0x01, no step_pulse. load with seed=0xA5 → q=0xA5, seg digit1=0x11, digit0=0x49.
- DIV=4, run held high for 255×4 cycles from q=0x01 → wrap pulses exactly once on the 255th step, period=255, q=0x01.
- DIV=3, run high with step_in edge coinciding with a tick → exactly one step. load in the same cycle as a tick → seed loaded, no step, next tick 3 cycles later.
- rst asserted while run active and cnt=100 → next cycle q=0x01, cnt=0, period=0, outputs quiet. step_in held high across reset release → no step.
